channel: RTL and testbench

Point-to-point synchronous rendezvous channel carrying one WIDTH-bit token from a single sender to a single receiver. Transfer completes only when both sides request in the same cycle. Sits between CSP-style producer, copy/fork and bucket blocks. Exposes channel status so a forking block can wait until all its output receivers are pending before sending. Optionally emits the transferred token in 1-of-4 one-hot encoding.

---
 rtl/channel_pkg.sv | 13 +
 rtl/channel_p1of4_enc.sv | 18 +
 rtl/channel.sv | 85 ++++++++
 tb/tb_channel.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// Shared types and constants for the rendezvous channel.
package channel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_PEND = 2'd1,
    R_PEND = 2'd2,
    XFER   = 2'd3
  } chan_status_e;

  localparam int P1OF4_GROUP_W = 4;

endpackage

// File: rtl/channel_p1of4_enc.sv
// Combinational 1-of-4 encoder: each 2-bit slice of data becomes a 4-bit one-hot group.
module channel_p1of4_enc
  import channel_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   data,
  output logic [2*WIDTH-1:0] code
);

  always_comb begin
    code = '0;
    for (int k = 0; k < WIDTH / 2; k++) begin
      code[P1OF4_GROUP_W*k +: P1OF4_GROUP_W] = 4'b0001 << data[2*k +: 2];
    end
  end

endmodule

// File: rtl/channel.sv
// Synchronous rendezvous channel between one sender and one receiver.
// Defining CHANNEL_P1OF4_EN builds the registered 1-of-4 encoded copy of r_data.
module channel
  import channel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_req,
  input  logic [WIDTH-1:0]   s_data,
  output logic               s_ack,
  input  logic               r_req,
  output logic               r_ack,
  output logic [WIDTH-1:0]   r_data,
  output logic [2*WIDTH-1:0] r_p1of4,
  output logic [1:0]         status,
  output logic [CNT_W-1:0]   xfer_count,
  output logic               proto_err
);

  chan_status_e state, nextState;
  logic             xferStart;
  logic [WIDTH-1:0] capData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // XFER always lasts exactly one cycle, which caps throughput at one token per two cycles.
  always_comb begin
    nextState = IDLE;
    if (state != XFER) begin
      if (s_req && r_req) nextState = XFER;
      else if (s_req)     nextState = S_PEND;
      else if (r_req)     nextState = R_PEND;
      else                nextState = IDLE;
    end
  end

  assign xferStart = (state != XFER) && s_req && r_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      xfer_count <= '0;
      capData    <= '0;
      proto_err  <= 1'b0;
    end else begin
      if (xferStart) begin
        r_data     <= s_data;
        xfer_count <= xfer_count + 1'b1;
      end
      // Remember the offered token so a change while waiting can be flagged.
      if (nextState == S_PEND && state != S_PEND) capData <= s_data;
      if (state == S_PEND && s_req && s_data != capData) proto_err <= 1'b1;
    end
  end

`ifdef CHANNEL_P1OF4_EN
  logic [2*WIDTH-1:0] encData;
  logic [2*WIDTH-1:0] p1of4Reg;

  channel_p1of4_enc #(.WIDTH(WIDTH)) u_enc (
    .data (s_data),
    .code (encData)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         p1of4Reg <= '0;
    else if (xferStart) p1of4Reg <= encData;
  end

  assign r_p1of4 = p1of4Reg;
`else
  assign r_p1of4 = '0;
`endif

  assign status = state;
  assign s_ack  = (state == XFER);
  assign r_ack  = (state == XFER);

endmodule

// File: tb/tb_channel.sv
// Directed self-checking bench for the rendezvous channel.
module tb_channel;

  logic        clk;
  logic        rst_n;
  logic        s_req;
  logic [7:0]  s_data;
  logic        s_ack;
  logic        r_req;
  logic        r_ack;
  logic [7:0]  r_data;
  logic [15:0] r_p1of4;
  logic [1:0]  status;
  logic [15:0] xfer_count;
  logic        proto_err;

  int totalChecks = 0;
  int badChecks   = 0;

  channel #(.WIDTH(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_req      (s_req),
    .s_data     (s_data),
    .s_ack      (s_ack),
    .r_req      (r_req),
    .r_ack      (r_ack),
    .r_data     (r_data),
    .r_p1of4    (r_p1of4),
    .status     (status),
    .xfer_count (xfer_count),
    .proto_err  (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic sReq, input logic rReq, input logic [7:0] data);
    s_req  = sReq;
    r_req  = rReq;
    s_data = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAll(input string tag, input logic [1:0] st, input logic ack,
                          input logic [7:0] rd, input logic [15:0] cnt, input logic err);
    checkOutput({tag, ".status"}, 32'(status), 32'(st));
    checkOutput({tag, ".s_ack"}, 32'(s_ack), 32'(ack));
    checkOutput({tag, ".r_ack"}, 32'(r_ack), 32'(ack));
    checkOutput({tag, ".r_data"}, 32'(r_data), 32'(rd));
    checkOutput({tag, ".count"}, 32'(xfer_count), 32'(cnt));
    checkOutput({tag, ".perr"}, 32'(proto_err), 32'(err));
  endtask

  logic [15:0] expB4;

  initial begin
`ifdef CHANNEL_P1OF4_EN
    expB4 = 16'h4821;
`else
    expB4 = 16'h0000;
`endif
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    #2;
    checkAll("reset", 2'd0, 1'b0, 8'h00, 16'd0, 1'b0);
    checkOutput("reset.p1of4", 32'(r_p1of4), 32'h0);
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;

    // Receiver arrives first
    tick();
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick();
    checkAll("rfirst.pend", 2'd2, 1'b0, 8'h00, 16'd0, 1'b0);
    tick();
    checkAll("rfirst.hold", 2'd2, 1'b0, 8'h00, 16'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h01);
    tick();
    checkAll("rfirst.xfer", 2'd3, 1'b1, 8'h01, 16'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkAll("rfirst.idle", 2'd0, 1'b0, 8'h01, 16'd1, 1'b0);

    // Sender arrives first
    applyStimulus(1'b1, 1'b0, 8'hB4);
    tick();
    checkAll("sfirst.pend", 2'd1, 1'b0, 8'h01, 16'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hB4);
    tick();
    checkAll("sfirst.xfer", 2'd3, 1'b1, 8'hB4, 16'd2, 1'b0);
    checkOutput("sfirst.p1of4", 32'(r_p1of4), 32'(expB4));
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkAll("sfirst.idle", 2'd0, 1'b0, 8'hB4, 16'd2, 1'b0);
    checkOutput("sfirst.p1of4hold", 32'(r_p1of4), 32'(expB4));

    // Back-to-back with both requests held: transfer every other cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i % 2));
      tick();
      checkAll($sformatf("b2b%0d.xfer", i), 2'd3, 1'b1, 8'(i % 2), 16'(3 + i), 1'b0);
      applyStimulus(1'b1, 1'b1, 8'((i + 1) % 2));
      tick();
      checkAll($sformatf("b2b%0d.gap", i), 2'd0, 1'b0, 8'(i % 2), 16'(3 + i), 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkAll("b2b.end", 2'd0, 1'b0, 8'h01, 16'd6, 1'b0);

    // Withdrawal is legal and does not flag an error
    applyStimulus(1'b1, 1'b0, 8'h33);
    tick();
    checkAll("wd.pend", 2'd1, 1'b0, 8'h01, 16'd6, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkAll("wd.idle", 2'd0, 1'b0, 8'h01, 16'd6, 1'b0);

    // Protocol error: data changes while sender waits
    applyStimulus(1'b1, 1'b0, 8'h05);
    tick();
    checkAll("perr.pend", 2'd1, 1'b0, 8'h01, 16'd6, 1'b0);
    tick();
    checkAll("perr.stable", 2'd1, 1'b0, 8'h01, 16'd6, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h06);
    tick();
    checkAll("perr.set", 2'd1, 1'b0, 8'h01, 16'd6, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h06);
    tick();
    checkAll("perr.xfer", 2'd3, 1'b1, 8'h06, 16'd7, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    checkAll("perr.sticky", 2'd0, 1'b0, 8'h06, 16'd7, 1'b1);

    // Abort: reset asserted during the transfer cycle
    applyStimulus(1'b1, 1'b1, 8'h77);
    tick();
    checkAll("abort.xfer", 2'd3, 1'b1, 8'h77, 16'd8, 1'b1);
    rst_n = 1'b0;
    #1;
    checkAll("abort.now", 2'd0, 1'b0, 8'h00, 16'd0, 1'b0);
    checkOutput("abort.p1of4", 32'(r_p1of4), 32'h0);
    tick();
    checkAll("abort.held", 2'd0, 1'b0, 8'h00, 16'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkAll("abort.after", 2'd0, 1'b0, 8'h00, 16'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
